// File: rtl/tabl_pkg.sv
// Shared definitions for the 4-input Boolean function F evaluator.
package tabl_pkg;

    // Bit i holds F(i); F is 1 for x = 0,2,6,7,9,11.
    localparam logic [15:0] TRUTH_MASK = 16'h0AC5;

    // Minimal disjunctive normal form of F.
    function automatic logic f_mdnf(input logic [3:0] x);
        return (x[3] & ~x[2] & x[0]) |
               (~x[3] & x[2] & x[1]) |
               (~x[3] & ~x[2] & ~x[0]);
    endfunction

    // Zhegalkin (algebraic normal form) polynomial of F.
    function automatic logic f_zheg(input logic [3:0] x);
        return 1'b1 ^ x[0] ^ x[2] ^ x[3] ^
               (x[0] & x[2]) ^ (x[1] & x[2]) ^ (x[2] & x[3]) ^
               (x[1] & x[2] & x[3]);
    endfunction

endpackage

// File: rtl/tabl_func_core.sv
// Combinational core: evaluates F by ROM lookup, MDNF and Zhegalkin form.
module tabl_func_core
    import tabl_pkg::*;
(
    input  logic [3:0] x,
    input  logic       fault_inj,
    output logic       r,
    output logic       m,
    output logic       z
);

    // All three forms side by side; fault_inj corrupts only the ROM path.
    always_comb begin
        r = TRUTH_MASK[x] ^ fault_inj;
        m = f_mdnf(x);
        z = f_zheg(x);
    end

endmodule

// File: rtl/tabl_eval_unit.sv
// Registered evaluator of F with cross-check, sticky error, ones counter and bus driver.
module tabl_eval_unit
    import tabl_pkg::*;
#(
    parameter bit          CHECK_EN = 1'b1,
    parameter int unsigned CNT_W    = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       x,
    input  logic             oe,
    input  logic             fault_inj,
    input  logic             clr_err,
    output logic             y,
    output logic             y_valid,
    output tri logic         y_bus,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] ones_cnt
);

    logic r;
    logic m;
    logic z;
    logic mis_next;

    tabl_func_core u_core (
        .x         (x),
        .fault_inj (fault_inj),
        .r         (r),
        .m         (m),
        .z         (z)
    );

    // Disagreement between the forms, only meaningful on a valid sample.
    always_comb begin
        mis_next = CHECK_EN & in_valid & ((r != m) | (r != z));
    end

    // Result, valid, mismatch, sticky error and saturating ones counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y          <= 1'b0;
            y_valid    <= 1'b0;
            mismatch   <= 1'b0;
            err_sticky <= 1'b0;
            ones_cnt   <= '0;
        end else begin
            y_valid  <= in_valid;
            mismatch <= mis_next;
            if (in_valid) begin
                y <= r;
            end
            if (in_valid && r && (ones_cnt != '1)) begin
                ones_cnt <= ones_cnt + CNT_W'(1);
            end
            // A new mismatch takes priority over a simultaneous clear.
            if (mis_next) begin
                err_sticky <= 1'b1;
            end else if (clr_err) begin
                err_sticky <= 1'b0;
            end
        end
    end

    assign y_bus = oe ? y : 1'bz;

endmodule

// File: tb/tb_tabl_eval_unit.sv
// Scoreboard bench for tabl_eval_unit, plus a 3-bit-counter instance for saturation.
module tb_tabl_eval_unit;

    typedef struct packed {
        logic       y;
        logic       mis;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    // Hand-computed F(x) for x = 0..15.
    localparam logic F_TAB [16] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                                    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] x = '0;
    logic       oe = 1'b1;
    logic       fault_inj = 1'b0;
    logic       clr_err = 1'b0;
    logic       y, y_valid, mismatch, err_sticky;
    logic [7:0] ones_cnt;
    wire        y_bus_w;
    pulldown (y_bus_w);

    logic       s_in_valid = 1'b0;
    logic [3:0] s_x = '0;
    logic       s_fault_inj = 1'b0;
    logic       s_y, s_y_valid, s_mismatch, s_err;
    logic [2:0] s_cnt;
    wire        s_y_bus_w;
    pulldown (s_y_bus_w);

    logic       m_y = 1'b0;
    logic       m_err = 1'b0;
    logic [7:0] m_cnt = '0;

    always #5 clk = ~clk;

    tabl_eval_unit #(.CHECK_EN(1'b1), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .x          (x),
        .oe         (oe),
        .fault_inj  (fault_inj),
        .clr_err    (clr_err),
        .y          (y),
        .y_valid    (y_valid),
        .y_bus      (y_bus_w),
        .mismatch   (mismatch),
        .err_sticky (err_sticky),
        .ones_cnt   (ones_cnt)
    );

    tabl_eval_unit #(.CHECK_EN(1'b0), .CNT_W(3)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (s_in_valid),
        .x          (s_x),
        .oe         (1'b0),
        .fault_inj  (s_fault_inj),
        .clr_err    (1'b0),
        .y          (s_y),
        .y_valid    (s_y_valid),
        .y_bus      (s_y_bus_w),
        .mismatch   (s_mismatch),
        .err_sticky (s_err),
        .ones_cnt   (s_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one valid sample and queue the response it should produce.
    task automatic issue(input logic [3:0] xv, input logic fi, input logic clr);
        logic r;
        in_valid  = 1'b1;
        x         = xv;
        fault_inj = fi;
        clr_err   = clr;
        r = F_TAB[xv] ^ fi;
        if (r && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        if (fi) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        m_y = r;
        sb_q.push_back('{y: r, mis: fi, err: m_err, cnt: m_cnt});
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        fault_inj = 1'b0;
        clr_err   = 1'b0;
    endtask

    // Drive one idle cycle and check held state directly.
    task automatic idle(input logic clr);
        in_valid = 1'b0;
        x        = 4'd6;
        clr_err  = clr;
        if (clr) m_err = 1'b0;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        check("idle_y", {31'b0, y}, {31'b0, m_y});
        check("idle_y_valid", {31'b0, y_valid}, 32'd0);
        check("idle_mismatch", {31'b0, mismatch}, 32'd0);
        check("idle_err", {31'b0, err_sticky}, {31'b0, m_err});
        check("idle_cnt", {24'b0, ones_cnt}, {24'b0, m_cnt});
    endtask

    // Monitor: every presented result must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && y_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got output y=%0b with empty queue, required none", y);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_y", {31'b0, y}, {31'b0, e.y});
                check("sb_mismatch", {31'b0, mismatch}, {31'b0, e.mis});
                check("sb_err", {31'b0, err_sticky}, {31'b0, e.err});
                check("sb_cnt", {24'b0, ones_cnt}, {24'b0, e.cnt});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, including bus reading y=0 with oe=1.
        #1;
        check("rst_y", {31'b0, y}, 32'd0);
        check("rst_y_valid", {31'b0, y_valid}, 32'd0);
        check("rst_cnt", {24'b0, ones_cnt}, 32'd0);
        check("rst_err", {31'b0, err_sticky}, 32'd0);
        check("rst_bus", {31'b0, y_bus_w}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Exhaustive sweep.
        for (int i = 0; i < 16; i++) issue(4'(i), 1'b0, 1'b0);
        idle(1'b0);
        check("sweep_cnt", {24'b0, ones_cnt}, 32'd6);

        // Async reset mid-sweep at x=9, with err_sticky set beforehand by a fault at x=8.
        for (int i = 0; i < 8; i++) issue(4'(i), 1'b0, 1'b0);
        issue(4'd8, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        check("pre_rst_err", {31'b0, err_sticky}, 32'd1);
        in_valid = 1'b1;
        x        = 4'd9;
        #2;
        rst = 1'b1;
        #1;
        check("arst_y", {31'b0, y}, 32'd0);
        check("arst_y_valid", {31'b0, y_valid}, 32'd0);
        check("arst_cnt", {24'b0, ones_cnt}, 32'd0);
        check("arst_err", {31'b0, err_sticky}, 32'd0);
        in_valid = 1'b0;
        m_y = 1'b0; m_cnt = '0; m_err = 1'b0;
        check("arst_queue", sb_q.size(), 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(4'd7, 1'b0, 1'b0);

        // Fault injection, mismatch pulse, sticky hold and clear.
        issue(4'd4, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b1);

        // Set wins over simultaneous clear.
        issue(4'd4, 1'b1, 1'b1);
        idle(1'b1);

        // Bus driver.
        issue(4'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("bus_oe1", {31'b0, y_bus_w}, 32'd1);
        oe = 1'b0;
        #1;
        check("bus_oe0_pulldown", {31'b0, y_bus_w}, 32'd0);
        oe = 1'b1;
        #1;
        check("bus_oe1_again", {31'b0, y_bus_w}, 32'd1);

        // Narrow counter with cross-check disabled.
        @(posedge clk);
        #1;
        s_in_valid  = 1'b1;
        s_x         = 4'd0;
        s_fault_inj = 1'b1;
        @(posedge clk);
        #1;
        s_fault_inj = 1'b0;
        check("sat_fault_y", {31'b0, s_y}, 32'd0);
        check("sat_chk_off_mis", {31'b0, s_mismatch}, 32'd0);
        check("sat_chk_off_err", {31'b0, s_err}, 32'd0);
        check("sat_fault_cnt", {29'b0, s_cnt}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        s_in_valid = 1'b0;
        s_x        = 4'd6;
        check("sat_cnt", {29'b0, s_cnt}, 32'd7);
        check("sat_y", {31'b0, s_y}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("sat_idle_y", {31'b0, s_y}, 32'd1);
            check("sat_idle_cnt", {29'b0, s_cnt}, 32'd7);
        end

        // All queued responses must have been consumed.
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
